// File: rtl/keypoint_collector.sv
// Keypoint collector: aligns DoG scan coordinates with the late detector flag,
// rejects border hits and queues accepted (x,y,dir) in a first-word-fall-through FIFO.
module keypoint_collector #(
    parameter int KP_LATENCY = 4,
    parameter int DEPTH      = 16,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int BORDER     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 Xin,
    input  logic [7:0]                 Yin,
    input  logic                       Directionin,
    input  logic                       coord_valid,
    input  logic                       keypoint,
    input  logic                       frame_start,
    output logic                       kp_valid,
    input  logic                       kp_ready,
    output logic [7:0]                 kp_x,
    output logic [7:0]                 kp_y,
    output logic                       kp_dir,
    output logic [15:0]                kp_count,
    output logic [15:0]                rej_count,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Bounds widened to 9 bits so IMG_W/IMG_H of 256 stay representable.
    localparam logic [8:0] X_LO = 9'(BORDER);
    localparam logic [8:0] X_HI = 9'(IMG_W - BORDER);
    localparam logic [8:0] Y_LO = 9'(BORDER);
    localparam logic [8:0] Y_HI = 9'(IMG_H - BORDER);

    typedef struct packed {
        logic       v;
        logic       dir;
        logic [7:0] y;
        logic [7:0] x;
    } coord_t;

    typedef struct packed {
        logic       dir;
        logic [7:0] y;
        logic [7:0] x;
    } entry_t;

    coord_t          dl_d [KP_LATENCY];
    coord_t          dl_q [KP_LATENCY];
    entry_t          mem_q [DEPTH];

    logic [AW-1:0]   wptr_d, wptr_q;
    logic [AW-1:0]   rptr_d, rptr_q;
    logic [LW-1:0]   level_d, level_q;
    entry_t          head_d, head_q;
    logic            kp_valid_d, kp_valid_q;
    logic [15:0]     kp_count_d, kp_count_q;
    logic [15:0]     rej_count_d, rej_count_q;
    logic            overflow_d, overflow_q;

    coord_t          d_s;
    entry_t          d_entry_s;
    logic            cand_s;
    logic            inside_s;
    logic            full_s;
    logic            pop_s;
    logic            push_req_s;
    logic            push_s;
    logic            drop_s;
    logic            rej_s;

    // Delay line next state: new coordinate enters stage 0, others shift by one.
    always_comb begin
        dl_d[0] = {coord_valid, Directionin, Yin, Xin};
        for (int i = 1; i < KP_LATENCY; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    // Candidate classification, FIFO control and statistics next state.
    always_comb begin
        d_s        = dl_q[KP_LATENCY-1];
        d_entry_s  = {d_s.dir, d_s.y, d_s.x};
        cand_s     = keypoint & d_s.v;
        inside_s   = ({1'b0, d_s.x} >= X_LO) && ({1'b0, d_s.x} < X_HI) &&
                     ({1'b0, d_s.y} >= Y_LO) && ({1'b0, d_s.y} < Y_HI);
        full_s     = (level_q == LW'(DEPTH));
        pop_s      = kp_valid_q & kp_ready;
        push_req_s = cand_s & inside_s;
        push_s     = push_req_s & (~full_s | pop_s);
        drop_s     = push_req_s & full_s & ~pop_s;
        rej_s      = cand_s & ~inside_s;

        wptr_d  = push_s ? (wptr_q + AW'(1)) : wptr_q;
        rptr_d  = pop_s  ? (rptr_q + AW'(1)) : rptr_q;

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Head register mirrors the entry that will be at the read pointer next cycle.
        if (pop_s) begin
            if (level_q == LW'(1)) begin
                head_d = push_s ? d_entry_s : '0;
            end else begin
                head_d = mem_q[rptr_q + AW'(1)];
            end
        end else if ((level_q == LW'(0)) && push_s) begin
            head_d = d_entry_s;
        end else begin
            head_d = head_q;
        end

        kp_valid_d = (level_d != LW'(0));

        if (frame_start) begin
            kp_count_d  = {15'd0, push_s};
            rej_count_d = {15'd0, rej_s};
            overflow_d  = drop_s;
        end else begin
            if (push_s && (kp_count_q != 16'hFFFF)) begin
                kp_count_d = kp_count_q + 16'd1;
            end else begin
                kp_count_d = kp_count_q;
            end
            if (rej_s && (rej_count_q != 16'hFFFF)) begin
                rej_count_d = rej_count_q + 16'd1;
            end else begin
                rej_count_d = rej_count_q;
            end
            overflow_d = overflow_q | drop_s;
        end
    end

    // Control, pointer, head and statistic registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KP_LATENCY; i++) begin
                dl_q[i] <= '0;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            head_q      <= '0;
            kp_valid_q  <= 1'b0;
            kp_count_q  <= 16'd0;
            rej_count_q <= 16'd0;
            overflow_q  <= 1'b0;
        end else begin
            for (int i = 0; i < KP_LATENCY; i++) begin
                dl_q[i] <= dl_d[i];
            end
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            head_q      <= head_d;
            kp_valid_q  <= kp_valid_d;
            kp_count_q  <= kp_count_d;
            rej_count_q <= rej_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage array; never read unless the level says the slot is occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= d_entry_s;
        end
    end

    assign kp_valid   = kp_valid_q;
    assign kp_x       = head_q.x;
    assign kp_y       = head_q.y;
    assign kp_dir     = head_q.dir;
    assign kp_count   = kp_count_q;
    assign rej_count  = rej_count_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_keypoint_collector.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_keypoint_collector;

    localparam int L      = 4;
    localparam int DEPTH  = 16;
    localparam int IMG_W  = 256;
    localparam int IMG_H  = 256;
    localparam int BORDER = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  Xin = 8'd0;
    logic [7:0]  Yin = 8'd0;
    logic        Directionin = 1'b0;
    logic        coord_valid = 1'b0;
    logic        keypoint = 1'b0;
    logic        frame_start = 1'b0;
    logic        kp_ready = 1'b0;
    logic        kp_valid;
    logic [7:0]  kp_x;
    logic [7:0]  kp_y;
    logic        kp_dir;
    logic [15:0] kp_count;
    logic [15:0] rej_count;
    logic        overflow;
    logic [$clog2(DEPTH):0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    keypoint_collector #(
        .KP_LATENCY(L), .DEPTH(DEPTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER(BORDER)
    ) dut (
        .clk(clk), .rst(rst), .Xin(Xin), .Yin(Yin), .Directionin(Directionin),
        .coord_valid(coord_valid), .keypoint(keypoint), .frame_start(frame_start),
        .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y),
        .kp_dir(kp_dir), .kp_count(kp_count), .rej_count(rej_count),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit d;
        int x;
        int y;
    } mc_t;

    mc_t hist[$];
    mc_t mfifo[$];
    int  m_kp, m_rej;
    bit  m_ovf;
    mc_t m_d, m_cur;
    bit  m_pop, m_cand, m_in, m_acc, m_drop, m_rej_ev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist = {};
            m_cur = '{v: 1'b0, d: 1'b0, x: 0, y: 0};
            for (int i = 0; i < L; i++) hist.push_back(m_cur);
            mfifo = {};
            m_kp = 0;
            m_rej = 0;
            m_ovf = 1'b0;
        end else begin
            m_d = hist.pop_front();
            m_cur.v = coord_valid;
            m_cur.d = Directionin;
            m_cur.x = int'(Xin);
            m_cur.y = int'(Yin);
            hist.push_back(m_cur);
            m_pop    = (mfifo.size() > 0) && kp_ready;
            m_cand   = keypoint && m_d.v;
            m_in     = (m_d.x >= BORDER) && (m_d.x < IMG_W - BORDER) &&
                       (m_d.y >= BORDER) && (m_d.y < IMG_H - BORDER);
            m_rej_ev = m_cand && !m_in;
            m_acc    = m_cand && m_in && ((mfifo.size() < DEPTH) || m_pop);
            m_drop   = m_cand && m_in && !m_acc;
            if (m_pop) void'(mfifo.pop_front());
            if (m_acc) mfifo.push_back(m_d);
            if (frame_start) begin
                m_kp  = m_acc ? 1 : 0;
                m_rej = m_rej_ev ? 1 : 0;
                m_ovf = m_drop;
            end else begin
                if (m_acc && m_kp < 65535) m_kp++;
                if (m_rej_ev && m_rej < 65535) m_rej++;
                m_ovf = m_ovf | m_drop;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_valid", int'(kp_valid), (mfifo.size() > 0) ? 1 : 0);
            chk("m_level", int'(fifo_level), mfifo.size());
            chk("m_kp_count", int'(kp_count), m_kp);
            chk("m_rej_count", int'(rej_count), m_rej);
            chk("m_overflow", int'(overflow), int'(m_ovf));
            if (mfifo.size() > 0) begin
                chk("m_kp_x", int'(kp_x), mfifo[0].x);
                chk("m_kp_y", int'(kp_y), mfifo[0].y);
                chk("m_kp_dir", int'(kp_dir), int'(mfifo[0].d));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit kp_sched[$];

    task automatic clear_sched();
        kp_sched = {};
        for (int i = 0; i < L; i++) kp_sched.push_back(1'b0);
    endtask

    task automatic cyc(input bit cv, input int x, input int y, input bit dir,
                       input bit want, input bit rdy, input bit fs);
        coord_valid = cv;
        Xin = x[7:0];
        Yin = y[7:0];
        Directionin = dir;
        kp_ready = rdy;
        frame_start = fs;
        keypoint = kp_sched.pop_front();
        kp_sched.push_back(want);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Presents a coordinate and waits until its flag has been consumed.
    task automatic push_kp(input int x, input int y, input bit dir, input bit rdy_last, input bit fs_last);
        cyc(1'b1, x, y, dir, 1'b1, 1'b0, 1'b0);
        repeat (L - 1) idle(1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, rdy_last, fs_last);
    endtask

    task automatic pop_chk(input int ex, input int ey);
        chk("head_valid", int'(kp_valid), 1);
        chk("head_x", int'(kp_x), ex);
        chk("head_y", int'(kp_y), ey);
        idle(1'b1);
    endtask

    task automatic do_reset();
        coord_valid = 1'b0;
        keypoint = 1'b0;
        frame_start = 1'b0;
        kp_ready = 1'b0;
        clear_sched();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(kp_valid), 0);
        chk({tag, "_x"}, int'(kp_x), 0);
        chk({tag, "_y"}, int'(kp_y), 0);
        chk({tag, "_dir"}, int'(kp_dir), 0);
        chk({tag, "_kp_count"}, int'(kp_count), 0);
        chk({tag, "_rej_count"}, int'(rej_count), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_level"}, int'(fifo_level), 0);
    endtask

    initial begin
        int kps;
        bit cv, want, rdy, fs;
        int x, y;
        int edges[4] = '{0, 1, 254, 255};

        do_reset();
        chk_all_zero("reset");

        // Latency: coordinate at cycle 0, flag at cycle 4, valid from cycle 5.
        cyc(1'b1, 10, 20, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        chk("lat_not_yet", int'(kp_valid), 0);
        idle(1'b0);
        chk("lat_valid", int'(kp_valid), 1);
        chk("lat_x", int'(kp_x), 10);
        chk("lat_y", int'(kp_y), 20);
        chk("lat_dir", int'(kp_dir), 1);
        chk("lat_count", int'(kp_count), 1);
        chk("lat_level", int'(fifo_level), 1);
        idle(1'b0);
        chk("lat_stall_x", int'(kp_x), 10);

        // Asynchronous reset mid-run.
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        clear_sched();
        @(posedge clk);
        #3 rst = 1'b0;

        // Border rejection.
        push_kp(0, 5, 1'b0, 1'b0, 1'b0);
        push_kp(255, 5, 1'b0, 1'b0, 1'b0);
        push_kp(5, 0, 1'b0, 1'b0, 1'b0);
        push_kp(1, 1, 1'b0, 1'b0, 1'b0);
        push_kp(254, 254, 1'b1, 1'b0, 1'b0);
        chk("bord_rej", int'(rej_count), 3);
        chk("bord_kp", int'(kp_count), 2);
        pop_chk(1, 1);
        pop_chk(254, 254);
        chk("bord_empty", int'(kp_valid), 0);

        // Overflow: 17 keypoints into a 16-deep FIFO without draining.
        do_reset();
        for (int i = 0; i < 17; i++) push_kp(10 + i, 3 + i, 1'b0, 1'b0, 1'b0);
        chk("ovf_level", int'(fifo_level), 16);
        chk("ovf_count", int'(kp_count), 16);
        chk("ovf_flag", int'(overflow), 1);
        for (int i = 0; i < 16; i++) pop_chk(10 + i, 3 + i);
        chk("ovf_drained", int'(kp_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Full FIFO with push and pop in the same cycle.
        do_reset();
        for (int i = 0; i < 16; i++) push_kp(30 + i, 40, 1'b0, 1'b0, 1'b0);
        push_kp(99, 98, 1'b1, 1'b1, 1'b0);
        chk("fpp_level", int'(fifo_level), 16);
        chk("fpp_ovf", int'(overflow), 0);
        chk("fpp_count", int'(kp_count), 17);
        for (int i = 1; i < 16; i++) pop_chk(30 + i, 40);
        pop_chk(99, 98);
        chk("fpp_empty", int'(kp_valid), 0);

        // frame_start clears statistics but keeps the FIFO.
        do_reset();
        for (int i = 0; i < 16; i++) push_kp(50 + i, 60, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fs_clr_count", int'(kp_count), 0);
        chk("fs_keep_level", int'(fifo_level), 16);
        push_kp(70, 70, 1'b0, 1'b0, 1'b0);
        chk("fs_ovf_set", int'(overflow), 1);
        for (int i = 0; i < 5; i++) pop_chk(50 + i, 60);
        for (int i = 0; i < 5; i++) push_kp(80 + i, 81, 1'b0, 1'b0, 1'b0);
        chk("fs_count5", int'(kp_count), 5);
        chk("fs_ovf1", int'(overflow), 1);
        pop_chk(55, 60);
        push_kp(90, 90, 1'b0, 1'b0, 1'b1);
        chk("fs_coinc_count", int'(kp_count), 1);
        chk("fs_coinc_ovf", int'(overflow), 0);
        chk("fs_coinc_level", int'(fifo_level), 16);
        chk("fs_head_kept", int'(kp_x), 56);
        repeat (20) idle(1'b1);

        // Randomised traffic with backpressure against the model.
        do_reset();
        kps = 0;
        while (kps < 100) begin
            cv   = ($urandom % 8) != 0;
            want = ($urandom % 3) == 0;
            rdy  = ($urandom % 4) != 0;
            fs   = ($urandom % 60) == 0;
            x = (($urandom % 4) == 0) ? edges[$urandom % 4] : int'($urandom % 256);
            y = (($urandom % 4) == 0) ? edges[$urandom % 4] : int'($urandom % 256);
            cyc(cv, x, y, 1'($urandom % 2), want, rdy, fs);
            if (cv && want) kps++;
        end
        repeat (L + 30) idle(1'b1);
        chk("rand_drained", int'(kp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
